// File: rtl/hellonios_multi_timer_pkg.sv
// Shared definitions for the multi-channel timer: register map, CONTROL/STATUS
// bit positions and the per-channel register readback record.
package hellonios_multi_timer_pkg;

  localparam logic [2:0] OFF_STATUS   = 3'd0;
  localparam logic [2:0] OFF_CONTROL  = 3'd1;
  localparam logic [2:0] OFF_PERIOD   = 3'd2;
  localparam logic [2:0] OFF_COMPARE  = 3'd3;
  localparam logic [2:0] OFF_SNAPSHOT = 3'd4;
  localparam logic [2:0] OFF_PRESCALE = 3'd5;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  localparam int CTRL_ITO    = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_START  = 2;
  localparam int CTRL_STOP   = 3;
  localparam int CTRL_PWM_EN = 4;

  // Readback view of one channel, already zero-extended to the bus width.
  typedef struct packed {
    logic [31:0] status;
    logic [31:0] control;
    logic [31:0] period;
    logic [31:0] compare;
    logic [31:0] snapshot;
    logic [31:0] prescale;
  } chan_regs_t;

endpackage

// File: rtl/hellonios_timer_channel.sv
// One timer channel: prescaler, down-counter with period reload, register file
// and registered PWM output.
module hellonios_timer_channel
  import hellonios_multi_timer_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int          PRE_W        = 16,
  parameter logic [31:0] RESET_PERIOD = 32'h05F5E0FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  offset,
  input  logic [31:0] writedata,
  output chan_regs_t  regs,
  output logic        irq,
  output logic        pwm_out
);

  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [CNT_W-1:0] compare_q, compare_d, snap_q, snap_d;
  logic [PRE_W-1:0] pre_q, pre_d, prescale_q, prescale_d;
  logic [4:0]       ctrl_q, ctrl_d;
  logic             run_q, run_d, to_q, to_d;
  logic             reload_q, reload_d, pwm_q, pwm_d;
  logic             tick, to_evt, start, stop;
  logic             unused_wd;

  assign unused_wd = ^writedata;

  always_comb begin
    cnt_d      = cnt_q;
    period_d   = period_q;
    compare_d  = compare_q;
    snap_d     = snap_q;
    pre_d      = pre_q;
    prescale_d = prescale_q;
    ctrl_d     = ctrl_q;
    run_d      = run_q;
    to_d       = to_q;
    reload_d   = 1'b0;
    to_evt     = 1'b0;
    start      = wr_en && (offset == OFF_CONTROL) && writedata[CTRL_START];
    stop       = wr_en && (offset == OFF_CONTROL) && writedata[CTRL_STOP];

    // >= keeps the tick period sane if PRESCALE is lowered below the live count
    tick = run_q && (pre_q >= prescale_q);
    if (run_q) pre_d = tick ? '0 : PRE_W'(pre_q + 1'b1);

    if (tick) begin
      if (cnt_q != '0) begin
        cnt_d = CNT_W'(cnt_q - 1'b1);
      end else begin
        to_evt = 1'b1;
        cnt_d  = period_q;
        if (!ctrl_q[CTRL_CONT]) run_d = 1'b0;
      end
    end

    // Second half of a PERIOD write: counter picks up the new period.
    if (reload_q) begin
      cnt_d = period_q;
      pre_d = '0;
    end

    if (wr_en) begin
      case (offset)
        OFF_STATUS:   to_d       = 1'b0;
        OFF_CONTROL:  ctrl_d     = writedata[4:0];
        OFF_PERIOD: begin
          period_d = writedata[CNT_W-1:0];
          reload_d = 1'b1;
          run_d    = 1'b0;
        end
        OFF_COMPARE:  compare_d  = writedata[CNT_W-1:0];
        OFF_SNAPSHOT: snap_d     = cnt_q;
        OFF_PRESCALE: prescale_d = writedata[PRE_W-1:0];
        default: ;
      endcase
    end

    if (to_evt) to_d = 1'b1;
    if (stop) run_d = 1'b0;
    if (start) begin
      run_d = 1'b1;
      pre_d = '0;
    end

    pwm_d = run_d && ctrl_d[CTRL_PWM_EN] && (cnt_d < compare_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= RESET_PERIOD[CNT_W-1:0];
      period_q   <= RESET_PERIOD[CNT_W-1:0];
      compare_q  <= '0;
      snap_q     <= '0;
      pre_q      <= '0;
      prescale_q <= '0;
      ctrl_q     <= '0;
      run_q      <= 1'b0;
      to_q       <= 1'b0;
      reload_q   <= 1'b0;
      pwm_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      compare_q  <= compare_d;
      snap_q     <= snap_d;
      pre_q      <= pre_d;
      prescale_q <= prescale_d;
      ctrl_q     <= ctrl_d;
      run_q      <= run_d;
      to_q       <= to_d;
      reload_q   <= reload_d;
      pwm_q      <= pwm_d;
    end
  end

  assign regs.status   = {30'd0, run_q, to_q};
  assign regs.control  = 32'(ctrl_q);
  assign regs.period   = 32'(period_q);
  assign regs.compare  = 32'(compare_q);
  assign regs.snapshot = 32'(snap_q);
  assign regs.prescale = 32'(prescale_q);
  assign irq           = to_q && ctrl_q[CTRL_ITO];
  assign pwm_out       = pwm_q;

endmodule

// File: rtl/hellonios_multi_timer.sv
// Multi-channel timer top: address decode, registered read mux and irq OR
// around NUM_CH independent timer channels.
module hellonios_multi_timer
  import hellonios_multi_timer_pkg::*;
#(
  parameter int          NUM_CH       = 2,
  parameter int          CNT_W        = 32,
  parameter int          PRE_W        = 16,
  parameter logic [31:0] RESET_PERIOD = 32'h05F5E0FF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(NUM_CH)+2:0]    address,
  input  logic                         chipselect,
  input  logic                         write_n,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  output logic                         irq,
  output logic [NUM_CH-1:0]            pwm_out
);

  localparam int AW   = $clog2(NUM_CH) + 3;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0]   ch_sel;
  logic [2:0]        offset;
  logic              ch_valid, wr;
  logic [NUM_CH-1:0] irq_ch;
  chan_regs_t        ch_regs [NUM_CH];
  chan_regs_t        sel_regs;
  logic [31:0]       readdata_q, readdata_d;

  generate
    if (NUM_CH > 1) begin : g_multi
      assign ch_sel = address[AW-1:3];
    end else begin : g_single
      assign ch_sel = '0;
    end
  endgenerate

  assign offset   = address[2:0];
  assign ch_valid = (int'(ch_sel) < NUM_CH);
  assign wr       = chipselect && !write_n && ch_valid;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    hellonios_timer_channel #(
      .CNT_W        (CNT_W),
      .PRE_W        (PRE_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr && (ch_sel == CH_W'(g))),
      .offset    (offset),
      .writedata (writedata),
      .regs      (ch_regs[g]),
      .irq       (irq_ch[g]),
      .pwm_out   (pwm_out[g])
    );
  end

  always_comb begin
    sel_regs   = '0;
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) sel_regs = ch_regs[i];
    end
    if (ch_valid) begin
      case (offset)
        OFF_STATUS:   readdata_d = sel_regs.status;
        OFF_CONTROL:  readdata_d = sel_regs.control;
        OFF_PERIOD:   readdata_d = sel_regs.period;
        OFF_COMPARE:  readdata_d = sel_regs.compare;
        OFF_SNAPSHOT: readdata_d = sel_regs.snapshot;
        OFF_PRESCALE: readdata_d = sel_regs.prescale;
        default:      readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = |irq_ch;

endmodule

// File: tb/tb_hellonios_multi_timer.sv
// Directed bench for hellonios_multi_timer (4 channels, 16-bit counters).
module tb_hellonios_multi_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  pwm_out;

  int checks = 0;
  int errors = 0;

  hellonios_multi_timer #(
    .NUM_CH (4),
    .CNT_W  (16),
    .PRE_W  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .pwm_out    (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic wr(input logic [1:0] ch, input logic [2:0] off, input logic [31:0] d);
    address = {ch, off}; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] ch, input logic [2:0] off, output logic [31:0] d);
    address = {ch, off}; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_irq(input int max, output int n);
    n = 0;
    while (!irq && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    logic [31:0] d;
    int          n, highs;
    logic [20:0] pw;

    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    idle(2);
    reset = 1'b0;

    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_pwm", {28'd0, pwm_out}, 32'h0);
    rd(2'd0, 3'd2, d); check("rst_period", d, 32'h0000E0FF);
    rd(2'd1, 3'd0, d); check("rst_status", d, 32'h0);
    rd(2'd0, 3'd3, d); check("rst_compare", d, 32'h0);

    // Continuous timeout on ch0
    wr(2'd0, 3'd2, 32'd4);
    wr(2'd0, 3'd1, 32'h07);
    wait_irq(20, n); check("cont_first_to", n, 32'd5);
    wr(2'd0, 3'd0, 32'h0);
    check("status_clr_irq", {31'd0, irq}, 32'h0);
    wait_irq(20, n); check("cont_second_to", n, 32'd4);
    idle(4);
    wr(2'd0, 3'd0, 32'h0);
    check("status_wr_in_to_cycle", {31'd0, irq}, 32'h1);
    wr(2'd0, 3'd1, 32'h08);
    wr(2'd0, 3'd0, 32'h0);
    rd(2'd0, 3'd0, d); check("stop_status", d, 32'h0);

    // PWM on ch0
    wr(2'd0, 3'd2, 32'd9);
    wr(2'd0, 3'd3, 32'd3);
    wr(2'd0, 3'd1, 32'h16);
    pw = '0; highs = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      pw[i] = pwm_out[0];
      if (pwm_out[0]) highs++;
    end
    check("pwm_highs_20clk", highs, 32'd6);
    check("pwm_low_before", {31'd0, pw[6]}, 32'h0);
    check("pwm_high_at_cnt2", {31'd0, pw[7]}, 32'h1);
    check("pwm_low_at_reload", {31'd0, pw[10]}, 32'h0);
    wr(2'd0, 3'd3, 32'd0);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pwm_out[0]) highs++;
    end
    check("pwm_cmp0", highs, 32'd0);
    wr(2'd0, 3'd3, 32'd20);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pwm_out[0]) highs++;
    end
    check("pwm_cmp_gt_period", highs, 32'd10);

    // PERIOD write while running
    wr(2'd0, 3'd2, 32'd7);
    check("period_wr_pwm_off", {31'd0, pwm_out[0]}, 32'h0);
    rd(2'd0, 3'd0, d); check("period_wr_run", d & 32'h2, 32'h0);
    wr(2'd0, 3'd4, 32'h0);
    rd(2'd0, 3'd4, d); check("period_wr_counter", d, 32'd7);

    // START + STOP together, then START in the reload cycle
    wr(2'd0, 3'd1, 32'h0C);
    rd(2'd0, 3'd0, d); check("start_stop_run", d & 32'h2, 32'h2);
    wr(2'd0, 3'd2, 32'd3);
    wr(2'd0, 3'd1, 32'h04);
    rd(2'd0, 3'd0, d); check("start_in_reload_run", d & 32'h2, 32'h2);

    // Prescaler on ch1, one-shot
    wr(2'd1, 3'd2, 32'd2);
    wr(2'd1, 3'd5, 32'd3);
    wr(2'd1, 3'd1, 32'h05);
    wait_irq(40, n); check("presc_to_clocks", n, 32'd12);
    rd(2'd1, 3'd0, d); check("presc_status", d, 32'h1);
    wr(2'd1, 3'd4, 32'h0);
    rd(2'd1, 3'd4, d); check("presc_snapshot", d, 32'd2);
    rd(2'd0, 3'd2, d); check("ch0_period_indep", d, 32'd3);
    rd(2'd1, 3'd5, d); check("ch1_prescale", d, 32'd3);

    // Reset mid-count on ch2, colliding with a START write
    wr(2'd2, 3'd2, 32'd50);
    wr(2'd2, 3'd3, 32'd100);
    wr(2'd2, 3'd1, 32'h17);
    idle(3);
    check("ch2_pwm_running", {31'd0, pwm_out[2]}, 32'h1);
    reset = 1'b1;
    address = {2'd2, 3'd1}; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h04;
    @(negedge clk);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    check("midrst_readdata", readdata, 32'h0);
    check("midrst_irq", {31'd0, irq}, 32'h0);
    check("midrst_pwm", {28'd0, pwm_out}, 32'h0);
    rd(2'd2, 3'd2, d); check("midrst_period", d, 32'h0000E0FF);
    rd(2'd2, 3'd0, d); check("midrst_status", d, 32'h0);
    rd(2'd2, 3'd1, d); check("midrst_control", d, 32'h0);
    wr(2'd3, 3'd6, 32'hFFFF_FFFF);
    rd(2'd3, 3'd6, d); check("unused_offset6", d, 32'h0);
    rd(2'd3, 3'd2, d); check("ch3_period", d, 32'h0000E0FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hellonios_multi_timer.md
HELLONIOS_MULTI_TIMER -- requirements
Module: hellonios_multi_timer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, giving the number of independent timer channels (1..4).
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the counter, period and compare width (8..32).
REQ-003 The block SHALL have parameter PRE_W, default 16, giving the prescaler width (1..16).
REQ-004 The block SHALL have parameter RESET_PERIOD, default 32'h05F5E0FF, as the reset period of every channel, truncated to CNT_W.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port address, input, clog2(NUM_CH)+3 bits: [high bits] = channel, [2:0] = register offset.
REQ-008 The block SHALL have ports chipselect (input, 1 bit) and write_n (input, 1 bit, active-low write).
REQ-009 The block SHALL have port writedata, input, 32 bits.
REQ-010 The block SHALL have port readdata, output, 32 bits, registered.
REQ-011 The block SHALL have port irq, output, 1 bit: OR of all channel interrupts.
REQ-012 The block SHALL have port pwm_out, output, NUM_CH bits: per-channel PWM output.

Function
REQ-013 The per-channel offsets SHALL be 0 STATUS {RUN[1], TO[0]}, 1 CONTROL {PWM_EN[4], STOP[3], START[2], CONT[1], ITO[0]}, 2 PERIOD, 3 COMPARE, 4 SNAPSHOT, 5 PRESCALE; offsets 6-7 and channel numbers >= NUM_CH SHALL read 0 and ignore writes.
REQ-014 A write SHALL be chipselect && !write_n; a read SHALL return the addressed value on readdata one cycle after the address is presented, with fixed 1-cycle latency and no wait states.
REQ-015 CONTROL SHALL store bits [4:0]; START and STOP SHALL act as strobes on write and SHALL read back as last written.
REQ-016 The prescaler SHALL generate one tick every PRESCALE+1 clocks while RUN=1; it SHALL restart from 0 on start or on reload.
REQ-017 On each tick, a non-zero counter SHALL decrement by 1.
REQ-018 On a tick with counter==0: TO SHALL be set and the counter SHALL reload PERIOD; if CONT=0, RUN SHALL also clear. The timeout period is therefore (PERIOD+1)*(PRESCALE+1) clocks.
REQ-019 A write to PERIOD SHALL load the new value into the counter on the following cycle and SHALL clear RUN (force reload).
REQ-020 If a STOP strobe coincides with a START strobe in the same CONTROL write, START SHALL win.
REQ-021 A START strobe coinciding with the force-reload cycle SHALL win, leaving RUN=1.
REQ-022 A STOP strobe SHALL hold the counter at its current value.
REQ-023 Any write to STATUS SHALL clear TO; if a timeout event occurs in the same cycle, TO SHALL be set (the event wins).
REQ-024 Any write to SNAPSHOT SHALL copy the live counter into SNAPSHOT on the next edge; SNAPSHOT reads SHALL return the captured value.
REQ-025 Channel irq SHALL be TO && ITO; the top-level irq SHALL be the combinational OR of the channel irqs.
REQ-026 pwm_out[ch] SHALL be registered and equal RUN && PWM_EN && (counter < COMPARE); COMPARE=0 SHALL give a constant 0 and COMPARE>PERIOD SHALL give a constant 1 while running.
REQ-027 Each channel SHALL run fully independently; writes to one channel SHALL NOT affect any other channel.

Reset
REQ-028 On reset=1 at a clk edge: counter=PERIOD=RESET_PERIOD; COMPARE=0; PRESCALE=0; SNAPSHOT=0; CONTROL=0; RUN=0; TO=0; prescaler=0; readdata=0; pwm_out=0; irq=0.
REQ-029 A reset asserted mid-count SHALL take precedence over every other event in the same cycle.

Structure
REQ-030 A shared package SHALL hold the register offset constants, the CONTROL/STATUS bit positions and the channel register record typedef.
REQ-031 One sub-module, hellonios_timer_channel (counter, prescaler, registers, PWM), SHALL be instantiated NUM_CH times.
REQ-032 The top level SHALL contain only address decode, the read mux and readdata register, and the irq OR.

Verification
REQ-033 Continuous timeout: ch0 PERIOD=4, PRESCALE=0, CONTROL=0x07 -> TO sets every 5 clocks; irq rises within 1 clock of TO; a STATUS write clears irq.
REQ-034 Prescaler: ch1 PERIOD=2, PRESCALE=3, CONTROL=0x05 -> TO after 12 clocks; RUN clears; counter reads back 2 via SNAPSHOT.
REQ-035 PWM: ch0 PERIOD=9, COMPARE=3, CONTROL=0x16 -> pwm_out[0] high 3 of every 10 clocks; with COMPARE=0 -> constantly 0.
REQ-036 Collisions: STATUS write in the timeout cycle -> TO stays 1; START+STOP in one write -> RUN=1; PERIOD write while running -> RUN=0 and counter=new PERIOD next cycle.
REQ-037 Reset mid-count with NUM_CH=4, CNT_W=16 -> all outputs 0; PERIOD reads 0xE0FF; an access to unused offset 6 returns 0.
